// File: rtl/pipeline_pkg.sv
// pipeline_pkg: redirect classes and default fetch constants shared by the IF stage
package pipeline_pkg;

    typedef enum logic [1:0] {
        SEQ    = 2'd0,
        JUMP   = 2'd1,
        BRANCH = 2'd2,
        EXC    = 2'd3
    } redir_cls_e;

    localparam int          INSTR_BYTES_DEFAULT  = 4;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT   = 32'h8000_0180;

endpackage

// File: rtl/redirect_buffer.sv
// redirect_buffer: holds one redirect that arrived while fetch was stalled, replacing it only by an equal-or-higher class
module redirect_buffer
    import pipeline_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            req_valid,
    input  redir_cls_e      req_cls,
    input  logic [XLEN-1:0] req_target,
    output logic            pend_valid,
    output redir_cls_e      pend_cls,
    output logic [XLEN-1:0] pend_target
);

    logic            valid_q, valid_d;
    redir_cls_e      cls_q, cls_d;
    logic [XLEN-1:0] target_q, target_d;

    // Capture while stalled if the slot is empty or the new request is at least as urgent; drop once fetch moves
    always_comb begin
        valid_d  = valid_q;
        cls_d    = cls_q;
        target_d = target_q;
        if (!stall) begin
            valid_d = 1'b0;
        end else if (req_valid && (!valid_q || req_cls >= cls_q)) begin
            valid_d  = 1'b1;
            cls_d    = req_cls;
            target_d = req_target;
        end
    end

    // Pending entry register; reset discards anything buffered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            cls_q    <= SEQ;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            cls_q    <= cls_d;
            target_q <= target_d;
        end
    end

    assign pend_valid  = valid_q;
    assign pend_cls    = cls_q;
    assign pend_target = target_q;

endmodule

// File: rtl/next_pc_unit.sv
// next_pc_unit: PC register and next-fetch-address selection with priority, stall hold and buffered redirects
module next_pc_unit
    import pipeline_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              JADDR_W      = 26,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
    parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(EXC_VECTOR_DEFAULT),
    parameter int              INSTR_BYTES  = INSTR_BYTES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               jump,
    input  logic [JADDR_W-1:0] jaddr,
    input  logic               jump_reg,
    input  logic [XLEN-1:0]    jr_target,
    input  logic               branch_taken,
    input  logic [XLEN-1:0]    branch_target,
    input  logic               exc,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    pc_plus,
    output logic               flush_if,
    output logic               flush_id,
    output logic               redirect_pending,
    output logic               misaligned
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] j_tgt, new_tgt, sel_tgt, pend_tgt;
    redir_cls_e      new_cls, sel_cls, pend_cls;
    logic            pend_valid, redirect;

    assign pc_plus = pc_q + XLEN'(INSTR_BYTES);
    // pc_q already points past the jump, so its upper bits form the region of the J target
    assign j_tgt   = {pc_q[XLEN-1:JADDR_W+2], jaddr, 2'b00};

    // Highest-priority request this cycle; jump_reg beats jump inside the JUMP class
    always_comb begin
        new_cls = exc ? EXC : branch_taken ? BRANCH : (jump || jump_reg) ? JUMP : SEQ;
        new_tgt = exc ? EXC_VECTOR : branch_taken ? branch_target :
                  jump_reg ? jr_target : jump ? j_tgt : pc_plus;
    end

    redirect_buffer #(.XLEN(XLEN)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .req_valid   (new_cls != SEQ),
        .req_cls     (new_cls),
        .req_target  (new_tgt),
        .pend_valid  (pend_valid),
        .pend_cls    (pend_cls),
        .pend_target (pend_tgt)
    );

    // Pending entry wins only when strictly more urgent; ties go to the fresh request
    always_comb begin
        sel_cls  = (pend_valid && pend_cls > new_cls) ? pend_cls : new_cls;
        sel_tgt  = (pend_valid && pend_cls > new_cls) ? pend_tgt : new_tgt;
        redirect = !rst && !stall && sel_cls != SEQ;
        pc_d     = stall ? pc_q : {sel_tgt[XLEN-1:2], 2'b00};
    end

    // PC register; fetch always proceeds at the word-aligned address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_VECTOR;
        else     pc_q <= pc_d;
    end

    assign pc               = pc_q;
    assign redirect_pending = pend_valid;
    assign flush_if         = redirect;
    assign flush_id         = redirect && sel_cls >= BRANCH;
    assign misaligned       = redirect && |sel_tgt[1:0];

endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: directed and random checks of next_pc_unit against a behavioural next-PC model
module tb_next_pc_unit;

    logic        clk = 1'b0;
    logic        rst, stall, jump, jump_reg, branch_taken, exc;
    logic [25:0] jaddr;
    logic [31:0] jr_target, branch_target;
    logic [31:0] pc, pc_plus;
    logic        flush_if, flush_id, redirect_pending, misaligned;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_pc, m_pt;
    logic        m_pv;
    int          m_pcls;
    logic        f_if, f_id, f_mis;

    always #5 clk = ~clk;

    next_pc_unit dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .jump             (jump),
        .jaddr            (jaddr),
        .jump_reg         (jump_reg),
        .jr_target        (jr_target),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .exc              (exc),
        .pc               (pc),
        .pc_plus          (pc_plus),
        .flush_if         (flush_if),
        .flush_id         (flush_id),
        .redirect_pending (redirect_pending),
        .misaligned       (misaligned)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic j, input logic [25:0] ja, input logic jr,
                         input logic [31:0] jrt, input logic b, input logic [31:0] bt, input logic e);
        stall = s; jump = j; jaddr = ja; jump_reg = jr; jr_target = jrt;
        branch_taken = b; branch_target = bt; exc = e;
    endtask

    // One cycle: compare outputs against the model, cross the rising edge, advance the model
    task automatic cyc();
        int          nc, sc;
        logic [31:0] nt, st;
        logic        e_if;
        #1;
        if (rst) begin
            m_pc = 32'h0;
            m_pv = 1'b0;
        end
        nc = 0;
        nt = m_pc + 32'd4;
        if (exc) begin
            nc = 3; nt = 32'h8000_0180;
        end else if (branch_taken) begin
            nc = 2; nt = branch_target;
        end else if (jump_reg) begin
            nc = 1; nt = jr_target;
        end else if (jump) begin
            nc = 1; nt = {m_pc[31:28], jaddr, 2'b00};
        end
        if (m_pv && m_pcls > nc) begin
            sc = m_pcls; st = m_pt;
        end else begin
            sc = nc; st = nt;
        end
        e_if = !rst && !stall && sc > 0;
        chk("pc", pc, m_pc);
        chk("pc_plus", pc_plus, m_pc + 32'd4);
        chk("redirect_pending", {31'd0, redirect_pending}, {31'd0, m_pv});
        chk("flush_if", {31'd0, flush_if}, {31'd0, e_if});
        chk("flush_id", {31'd0, flush_id}, {31'd0, e_if && sc >= 2});
        chk("misaligned", {31'd0, misaligned}, {31'd0, e_if && st[1:0] != 2'b00});
        f_if = flush_if; f_id = flush_id; f_mis = misaligned;
        @(posedge clk);
        if (!rst) begin
            if (!stall) begin
                m_pc = {st[31:2], 2'b00};
                m_pv = 1'b0;
            end else if (nc > 0 && (!m_pv || nc >= m_pcls)) begin
                m_pv = 1'b1; m_pcls = nc; m_pt = nt;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        m_pc = 32'h0; m_pv = 1'b0; m_pcls = 0; m_pt = 32'h0;
        rst = 1'b1;
        drive(0, 1, 26'h3, 0, 0, 0, 0, 0);
        @(negedge clk);
        cyc();
        cyc();
        chk("lit_reset_pc", pc, 32'h0);
        chk("lit_reset_flush", {30'd0, f_if, f_id}, 32'h0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        chk("lit_seq_4", pc, 32'h4);
        cyc();
        chk("lit_seq_8", pc, 32'h8);
        chk("lit_seq_flush", {31'd0, f_if}, 32'h0);

        drive(0, 0, 0, 1, 32'h0040_0010, 0, 0, 0);
        cyc();
        drive(0, 1, 26'h010_0000, 0, 0, 0, 0, 0);
        cyc();
        chk("lit_j_flush", {30'd0, f_if, f_id}, 32'h2);
        chk("lit_j_pc", pc, 32'h0040_0000);

        drive(0, 1, 26'h3, 0, 0, 1, 32'h0040_0100, 0);
        cyc();
        chk("lit_simul_flush", {30'd0, f_if, f_id}, 32'h3);
        chk("lit_simul_pc", pc, 32'h0040_0100);

        drive(1, 0, 0, 1, 32'h0000_2000, 0, 0, 0);
        cyc();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        chk("lit_stall_hold", pc, 32'h0040_0100);
        chk("lit_stall_pend", {31'd0, redirect_pending}, 32'h1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        chk("lit_release_pc", pc, 32'h0000_2000);
        chk("lit_release_pend", {31'd0, redirect_pending}, 32'h0);

        drive(1, 0, 0, 0, 0, 1, 32'h0000_3000, 0);
        cyc();
        drive(1, 1, 26'h0000_0040, 0, 0, 0, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        chk("lit_branch_kept", pc, 32'h0000_3000);

        drive(1, 0, 0, 0, 0, 1, 32'h0000_4000, 0);
        cyc();
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        chk("lit_exc_flush", {30'd0, f_if, f_id}, 32'h3);
        chk("lit_exc_pc", pc, 32'h8000_0180);

        drive(1, 0, 0, 0, 0, 1, 32'h0000_5000, 0);
        cyc();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("lit_async_rst_pc", pc, 32'h0);
        chk("lit_async_rst_pend", {31'd0, redirect_pending}, 32'h0);
        cyc();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        chk("lit_post_rst_pc", pc, 32'h4);

        drive(0, 0, 0, 1, 32'h0000_2002, 0, 0, 0);
        cyc();
        chk("lit_misaligned", {31'd0, f_mis}, 32'h1);
        chk("lit_misaligned_pc", pc, 32'h0000_2000);

        drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        cyc();
        chk("lit_wrap_plus", pc_plus, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        chk("lit_wrap_pc", pc, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 9) < 4, $urandom_range(0, 4) == 0, 26'($urandom),
                  $urandom_range(0, 4) == 0, $urandom & ~32'($urandom_range(0, 1) * 3),
                  $urandom_range(0, 4) == 0, $urandom & ~32'($urandom_range(0, 1) * 3),
                  $urandom_range(0, 15) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
